// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, data load/store port and shared memory port.
// The arbiter takes the slave view; requesters plus memory take the master view.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int XLEN       = 64
);
   logic                    if_req;
   logic [ADDR_WIDTH-1:0]   if_addr;
   logic                    if_gnt;
   logic                    if_rvalid;
   logic [XLEN-1:0]         if_rdata;

   logic                    d_req;
   logic [ADDR_WIDTH-1:0]   d_addr;
   logic [XLEN/8-1:0]       d_we;
   logic [XLEN-1:0]         d_wdata;
   logic                    d_gnt;
   logic                    d_rvalid;
   logic [XLEN-1:0]         d_rdata;

   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic                    mem_re;
   logic [XLEN/8-1:0]       mem_we;
   logic [XLEN-1:0]         mem_wdata;
   logic [XLEN-1:0]         mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_addr, mem_re, mem_we, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_addr, d_we, d_wdata, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter (fetch read-only, data read/write) onto one shared memory, data priority
// with fetch starvation guard. Define MEM_ARB_STATS_EN to add grant/conflict statistics outputs.
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 10,
   parameter int XLEN         = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef MEM_ARB_STATS_EN
   output logic [31:0]        stat_if_grants,
   output logic [31:0]        stat_d_grants,
   output logic [31:0]        stat_conflicts,
`endif
   mem_arbiter_if.slave       bus
);
   localparam int BE_W = XLEN / 8;
   localparam int SW   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_IF   = 2'd1,
      TAG_D    = 2'd2
   } resp_tag_e;

   resp_tag_e       resp_tag_q, resp_tag_d;
   logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
   logic            if_gnt_s, d_gnt_s, d_read_s, starve_win_s;

   // Grant decision; gated by rst_n so grants vanish the instant reset asserts.
   always_comb begin
      d_read_s     = (bus.d_we == {BE_W{1'b0}});
      starve_win_s = (STARVE_LIMIT != 32'sd0) && (starve_cnt_q >= STARVE_MAX);
      if_gnt_s     = 1'b0;
      d_gnt_s      = 1'b0;
      if (!rst_n) begin
         if_gnt_s = 1'b0;
         d_gnt_s  = 1'b0;
      end else if (bus.if_req && bus.d_req) begin
         if (starve_win_s) begin
            if_gnt_s = 1'b1;
         end else begin
            d_gnt_s = 1'b1;
         end
      end else if (bus.if_req) begin
         if_gnt_s = 1'b1;
      end else if (bus.d_req) begin
         d_gnt_s = 1'b1;
      end else begin
         if_gnt_s = 1'b0;
         d_gnt_s  = 1'b0;
      end
   end

   // Memory drive from the granted port; idle cycles park the address on fetch.
   always_comb begin
      bus.if_gnt    = if_gnt_s;
      bus.d_gnt     = d_gnt_s;
      bus.mem_addr  = d_gnt_s ? bus.d_addr : bus.if_addr;
      bus.mem_re    = if_gnt_s | (d_gnt_s & d_read_s);
      bus.mem_we    = d_gnt_s ? bus.d_we : {BE_W{1'b0}};
      bus.mem_wdata = bus.d_wdata;
   end

   // Next response owner and starvation count.
   always_comb begin
      resp_tag_d   = TAG_NONE;
      starve_cnt_d = starve_cnt_q;
      if (if_gnt_s) begin
         resp_tag_d = TAG_IF;
      end else if (d_gnt_s && d_read_s) begin
         resp_tag_d = TAG_D;
      end else begin
         resp_tag_d = TAG_NONE;
      end
      if (bus.if_req && !if_gnt_s) begin
         if (starve_cnt_q >= STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q;
         end else begin
            starve_cnt_d = starve_cnt_q + SW'(1);
         end
      end else begin
         starve_cnt_d = {SW{1'b0}};
      end
   end

   // Response routing: memory data is valid the cycle after the read grant.
   always_comb begin
      bus.if_rvalid = 1'b0;
      bus.d_rvalid  = 1'b0;
      bus.if_rdata  = bus.mem_rdata;
      bus.d_rdata   = bus.mem_rdata;
      case (resp_tag_q)
         TAG_IF:   bus.if_rvalid = 1'b1;
         TAG_D:    bus.d_rvalid  = 1'b1;
         TAG_NONE: bus.if_rvalid = 1'b0;
         default:  bus.d_rvalid  = 1'b0;
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_tag_q   <= TAG_NONE;
         starve_cnt_q <= {SW{1'b0}};
      end else begin
         resp_tag_q   <= resp_tag_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic [31:0] stat_if_q, stat_if_d;
   logic [31:0] stat_d_q,  stat_d_d;
   logic [31:0] stat_c_q,  stat_c_d;

   // Free-running wrap-around event counters.
   always_comb begin
      stat_if_d = if_gnt_s ? stat_if_q + 32'd1 : stat_if_q;
      stat_d_d  = d_gnt_s  ? stat_d_q  + 32'd1 : stat_d_q;
      stat_c_d  = (bus.if_req && bus.d_req) ? stat_c_q + 32'd1 : stat_c_q;
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_if_q <= 32'd0;
         stat_d_q  <= 32'd0;
         stat_c_q  <= 32'd0;
      end else begin
         stat_if_q <= stat_if_d;
         stat_d_q  <= stat_d_d;
         stat_c_q  <= stat_c_d;
      end
   end

   assign stat_if_grants = stat_if_q;
   assign stat_d_grants  = stat_d_q;
   assign stat_conflicts = stat_c_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level reference model and a shadow memory.
module tb_mem_arbiter;
   localparam int AW = 10;
   localparam int XL = 64;
   localparam int BW = 8;
   localparam int SL = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .XLEN(XL)) bus ();

`ifdef MEM_ARB_STATS_EN
   logic [31:0] s_if, s_d, s_c;
`endif

   mem_arbiter #(.ADDR_WIDTH(AW), .XLEN(XL), .STARVE_LIMIT(SL)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
`ifdef MEM_ARB_STATS_EN
      .stat_if_grants (s_if),
      .stat_d_grants  (s_d),
      .stat_conflicts (s_c),
`endif
      .bus            (bus)
   );

   function automatic logic [63:0] init_word(int a);
      if (a == 4) return 64'h00000013_00000093;
      return {32'(a) * 32'h9E3779B9, ~(32'(a) * 32'h85EBCA6B)};
   endfunction

   function automatic logic [63:0] merge(logic [63:0] old, logic [7:0] we, logic [63:0] wd);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   // Environment memory: synchronous read, byte-enabled write.
   logic [XL-1:0] env_mem [0:1023];
   bit            env_wr  [0:1023];

   function automatic logic [63:0] env_rd(logic [AW-1:0] a);
      return env_wr[a] ? env_mem[a] : init_word(int'(a));
   endfunction

   always @(posedge clk) begin
      if (bus.mem_re) bus.mem_rdata <= env_rd(bus.mem_addr);
      if (|bus.mem_we) begin
         env_mem[bus.mem_addr] <= merge(env_rd(bus.mem_addr), bus.mem_we, bus.mem_wdata);
         env_wr[bus.mem_addr]  <= 1'b1;
      end
   end

   // Reference model state
   logic [63:0] ref_mem [0:1023];
   int   denied;
   bit   fw, dw;
   bit   exp_if_v, exp_d_v;
   logic [63:0] exp_if_d, exp_d_d;
   int   n_if, n_d, n_c;
   int   checks = 0;
   int   errors = 0;

   task automatic chk1(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk64(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      denied   = 0;
      exp_if_v = 1'b0;
      exp_d_v  = 1'b0;
      n_if     = 0;
      n_d      = 0;
      n_c      = 0;
   endtask

   // Called at the falling edge after inputs are set: checks grants and memory drive.
   task automatic pre_edge();
      #1;
      fw = bus.if_req && (!bus.d_req || (SL != 0 && denied >= SL));
      dw = bus.d_req && !fw;
      chk1("if_gnt", bus.if_gnt, fw);
      chk1("d_gnt", bus.d_gnt, dw);
      chk1("mem_re", bus.mem_re, fw || (dw && bus.d_we == 8'h00));
      chk64("mem_we", 64'(bus.mem_we), dw ? 64'(bus.d_we) : 64'd0);
      chk64("mem_addr", 64'(bus.mem_addr), dw ? 64'(bus.d_addr) : 64'(bus.if_addr));
      if (dw && bus.d_we != 8'h00) chk64("mem_wdata", bus.mem_wdata, bus.d_wdata);
      exp_if_v = fw;
      exp_if_d = ref_mem[bus.if_addr];
      exp_d_v  = dw && (bus.d_we == 8'h00);
      exp_d_d  = ref_mem[bus.d_addr];
      if (dw && bus.d_we != 8'h00) ref_mem[bus.d_addr] = merge(ref_mem[bus.d_addr], bus.d_we, bus.d_wdata);
      if (bus.if_req && !fw) denied = (denied < SL) ? denied + 1 : denied;
      else denied = 0;
      n_if += int'(fw);
      n_d  += int'(dw);
      n_c  += int'(bus.if_req && bus.d_req);
   endtask

   task automatic post_edge();
      chk1("if_rvalid", bus.if_rvalid, exp_if_v);
      chk1("d_rvalid", bus.d_rvalid, exp_d_v);
      if (exp_if_v) chk64("if_rdata", bus.if_rdata, exp_if_d);
      if (exp_d_v)  chk64("d_rdata", bus.d_rdata, exp_d_d);
   endtask

   task automatic edge_and_check();
      @(posedge clk);
      #1;
      post_edge();
   endtask

   task automatic cycle();
      pre_edge();
      edge_and_check();
      @(negedge clk);
   endtask

   task automatic set_if(logic r, logic [AW-1:0] a);
      bus.if_req  = r;
      bus.if_addr = a;
   endtask

   task automatic set_d(logic r, logic [AW-1:0] a, logic [7:0] we, logic [63:0] wd);
      bus.d_req   = r;
      bus.d_addr  = a;
      bus.d_we    = we;
      bus.d_wdata = wd;
   endtask

`ifdef MEM_ARB_STATS_EN
   task automatic chk_stats(string tag);
      chk64({tag, "_if"}, 64'(s_if), 64'(n_if));
      chk64({tag, "_d"},  64'(s_d),  64'(n_d));
      chk64({tag, "_c"},  64'(s_c),  64'(n_c));
   endtask
`endif

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
      model_reset();
      set_if(1'b1, 10'h000);
      set_d(1'b1, 10'h001, 8'h00, 64'd0);
      @(negedge clk);
      #1;
      chk1("rst_if_gnt", bus.if_gnt, 1'b0);
      chk1("rst_d_gnt", bus.d_gnt, 1'b0);
      chk1("rst_mem_re", bus.mem_re, 1'b0);
      chk64("rst_mem_we", 64'(bus.mem_we), 64'd0);
      chk1("rst_if_rvalid", bus.if_rvalid, 1'b0);
      chk1("rst_d_rvalid", bus.d_rvalid, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Conflict: both held high for 10 cycles
      set_if(1'b1, 10'h008);
      set_d(1'b1, 10'h009, 8'h00, 64'd0);
      for (int i = 0; i < 10; i++) begin
         pre_edge();
         chk1("conflict_if_gnt", bus.if_gnt, (i == 4 || i == 9));
         chk1("conflict_one_hot", bus.if_gnt & bus.d_gnt, 1'b0);
         edge_and_check();
         @(negedge clk);
      end
`ifdef MEM_ARB_STATS_EN
      chk64("stats_d_grants", 64'(s_d), 64'd8);
      chk64("stats_if_grants", 64'(s_if), 64'd2);
      chk64("stats_conflicts", 64'(s_c), 64'd10);
`endif
      set_if(1'b0, 10'h000);
      set_d(1'b0, 10'h000, 8'h00, 64'd0);
      cycle();

      // Fetch only
      set_if(1'b1, 10'h004);
      pre_edge();
      chk64("tp_fetch_addr", 64'(bus.mem_addr), 64'h004);
      chk1("tp_fetch_re", bus.mem_re, 1'b1);
      edge_and_check();
      chk64("tp_fetch_rdata", bus.if_rdata, 64'h00000013_00000093);
      @(negedge clk);
      set_if(1'b0, 10'h000);

      // Data write then read
      set_d(1'b1, 10'h100, 8'hFF, 64'hDEADBEEF_CAFEF00D);
      pre_edge();
      edge_and_check();
      chk1("tp_wr_no_rvalid", bus.d_rvalid, 1'b0);
      @(negedge clk);
      set_d(1'b1, 10'h100, 8'h00, 64'd0);
      pre_edge();
      edge_and_check();
      chk1("tp_rd_rvalid", bus.d_rvalid, 1'b1);
      chk64("tp_rd_rdata", bus.d_rdata, 64'hDEADBEEF_CAFEF00D);
      @(negedge clk);
      set_d(1'b0, 10'h000, 8'h00, 64'd0);

      // Back-to-back fetch then data read
      set_if(1'b1, 10'h010);
      pre_edge();
      edge_and_check();
      chk64("b2b_if_rdata", bus.if_rdata, init_word(16));
      @(negedge clk);
      set_if(1'b0, 10'h000);
      set_d(1'b1, 10'h020, 8'h00, 64'd0);
      pre_edge();
      chk1("b2b_overlap_rvalid", bus.if_rvalid, 1'b1);
      edge_and_check();
      chk64("b2b_d_rdata", bus.d_rdata, init_word(32));
      @(negedge clk);
      set_d(1'b0, 10'h000, 8'h00, 64'd0);
      cycle();

      // Reset after starving fetch with a data read in flight
      set_if(1'b1, 10'h030);
      set_d(1'b1, 10'h031, 8'h00, 64'd0);
      for (int i = 0; i < 3; i++) cycle();
      pre_edge();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk1("arst_d_rvalid", bus.d_rvalid, 1'b0);
      chk1("arst_if_gnt", bus.if_gnt, 1'b0);
      chk1("arst_d_gnt", bus.d_gnt, 1'b0);
      chk1("arst_mem_re", bus.mem_re, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      pre_edge();
      chk1("arst_first_conflict_d", bus.d_gnt, 1'b1);
      edge_and_check();
      @(negedge clk);

      // Reset right after a fetch grant
      set_d(1'b0, 10'h000, 8'h00, 64'd0);
      cycle();
      pre_edge();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk1("arst_if_rvalid", bus.if_rvalid, 1'b0);
      chk1("arst_if_gnt2", bus.if_gnt, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      set_if(1'b0, 10'h000);
      cycle();

      // Randomized traffic; requests hold until granted
      fw = 1'b1;
      dw = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (!bus.if_req || fw)
            set_if(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 15)));
         if (!bus.d_req || dw) begin
            case ($urandom_range(0, 3))
               0:       set_d(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 15)), 8'h00, 64'd0);
               1:       set_d(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 15)), 8'hFF, {$urandom, $urandom});
               2:       set_d(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 15)), 8'($urandom), {$urandom, $urandom});
               default: set_d(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 15)), 8'h00, 64'd0);
            endcase
         end
         cycle();
      end
`ifdef MEM_ARB_STATS_EN
      chk_stats("rand_stats");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared 64-bit memory between two requesters: the instruction-fetch port (read-only) and the data load/store port (read/write with byte enables).
- Sits between fetch/LSU and memory, replacing the fetch-only memory hookup in the core top level.
- Single-cycle grant, one-cycle read response, back-to-back issue every cycle.
- Data port has priority by default; a starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_WIDTH, 10, memory word-address width.
- XLEN, 64, data width; byte-enable width is XLEN/8.
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch wins one conflict; 0 means data always wins.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_WIDTH  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  XLEN  fetch read data.
- d_req  in  1  data request.
- d_addr  in  ADDR_WIDTH  data word address.
- d_we  in  XLEN/8  byte write enables; all-zero means read.
- d_wdata  in  XLEN  write data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read data valid; never asserted for writes.
- d_rdata  out  XLEN  data read data.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_re  out  1  memory read enable.
- mem_we  out  XLEN/8  memory byte write enables.
- mem_wdata  out  XLEN  memory write data.
- mem_rdata  in  XLEN  memory read data, valid the cycle after mem_re.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Registered state clears: resp_tag=NONE, starve_cnt=0.
  - Gnts, rvalids, mem_re and mem_we are all 0 while rst_n is low.
  - rdata outputs are don't-care.
- Requester rules:
  - Hold req, addr, we and wdata stable until gnt is seen.
  - The transfer completes on the edge where req && gnt.
- Grant (combinational, same cycle):
  - Only if_req: if_gnt=1.
  - Only d_req: d_gnt=1.
  - Both: d_gnt=1, unless STARVE_LIMIT!=0 and starve_cnt>=STARVE_LIMIT, in which case if_gnt=1.
  - At most one gnt is high per cycle.
- Memory drive, from the granted port:
  - mem_addr follows the granted port's address.
  - mem_re=1 for a fetch grant, or a data grant with d_we==0.
  - mem_we=d_we only on a data grant; otherwise 0.
  - mem_wdata=d_wdata.
  - With no grant: mem_re=0, mem_we=0, and mem_addr holds the fetch address.
- Response FSM, resp_tag in {NONE, IF, D}, registered at each edge:
  - Fetch read granted: IF.
  - Data read granted: D.
  - Otherwise, including writes: NONE.
- Response outputs:
  - resp_tag==IF: if_rvalid=1, if_rdata=mem_rdata.
  - resp_tag==D: d_rvalid=1, d_rdata=mem_rdata.
  - Read latency is exactly 1 cycle from the grant edge.
  - A new grant may be issued in the same cycle a response is returned (full throughput).
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, each cycle if_req && !if_gnt.
  - Clears to 0 on any if_gnt, or when if_req=0.
  - Width is clog2(STARVE_LIMIT+1), minimum 1.
- Reset mid-operation: any pending response is dropped and no rvalid follows. Requesters must re-issue.
- Write then read to the same address in consecutive cycles returns the new data; this relies on the memory's write-before-read ordering. The arbiter does no forwarding.

Optional Feature:
- Macro MEM_ARB_STATS_EN.
- When defined, adds three 32-bit outputs: stat_if_grants, stat_d_grants, stat_conflicts (cycles with if_req && d_req).
- All three are cleared on reset, increment at each edge when their condition holds, and wrap at 2^32.
- When undefined, these ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Fetch only: if_req=1, if_addr=0x004, mem word 4=0x00000013_00000093 -> if_gnt same cycle, mem_re=1, mem_addr=0x004; next cycle if_rvalid=1, if_rdata=0x00000013_00000093.
- Data write then read: d_req=1, d_addr=0x100, d_we=0xFF, d_wdata=0xDEADBEEF_CAFEF00D, then d_we=0x00 -> d_gnt both cycles; no d_rvalid after the write; d_rvalid with 0xDEADBEEF_CAFEF00D after the read.
- Conflict with STARVE_LIMIT=4: if_req and d_req held high for 10 cycles -> d_gnt cycles 0-3, if_gnt cycle 4, d_gnt cycles 5-8, if_gnt cycle 9; never both gnts high.
- Back-to-back alternation, fetch addr 0x010 then data read 0x020 on consecutive cycles -> if_rvalid then d_rvalid on consecutive cycles with the correct words, with no bubble.
- Async reset: drop rst_n mid-cycle after a fetch grant -> if_rvalid stays 0 and gnts drop immediately; after release, starve_cnt=0 and the first conflict grants data.
- MEM_ARB_STATS_EN: run the conflict scenario above -> stat_d_grants=8, stat_if_grants=2, stat_conflicts=10.
